fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Issue controller and arbiter that shares one `fpu` datapath between two requesters. Each cycle it round-robin arbitrates between requesters whose operation can legally issue. It launches at most one operation into the FPU and tracks in-flight operations by latency class. It rules out writeback collisions on the single FPU result bus and returns each result, tagged with its requester, one cycle after the FPU produces it.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (`BIT_SIZE`+1)
- `LAT_ADD`, 2, add/sub latency in cycles (pipelined)
- `LAT_MUL`, 3, multiply latency (pipelined)
- `LAT_DIV`, 8, divide latency (non-pipelined, must be the largest)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req0_valid`, `req1_valid` in 1: request present
- `req0_ready`, `req1_ready` out 1: grant this cycle; handshake completes when valid&ready
- `req0_op`, `req1_op` in 2: 00 add, 01 sub, 10 mul, 11 div
- `req0_opa`, `req0_opb`, `req1_opa`, `req1_opb` in WIDTH: operands
- `fpu_start` out 1: launch strobe to the FPU
- `fpu_op` out 2: operation to the FPU
- `fpu_opa`, `fpu_opb` out WIDTH: operands to the FPU
- `fpu_out` in WIDTH: FPU result
- `fpu_errors` in 1: FPU error flag, valid with `fpu_out`
- `rsp_valid` out 1: response strobe (no backpressure)
- `rsp_id` out 1: requester index
- `rsp_data` out WIDTH: result
- `rsp_error` out 1: captured error flag

## Operation
- Latency of op: L = LAT_ADD for 00/01, LAT_MUL for 10, LAT_DIV for 11.
- Writeback reservation vector `wb[1..LAT_DIV]`: `wb[k]`=1 means an FPU result appears k cycles from now. It shifts down by one each cycle.
- A request is eligible when valid, `wb[L]`=0, and, if it is a div, `div_cnt`=0.
- Arbitration: if only one requester is eligible, it is granted. If both are, the requester indicated by `rr_ptr` wins. After any grant, `rr_ptr` points to the other requester.
- `reqN_ready` is combinational and equals the grant. A valid requester must hold its op and operands stable until it is granted.
- On a grant:
  - `fpu_start`=1 with the granted op and operands (combinational mux).
  - `wb[L]` is set.
  - The requester id is pushed into the tag pipeline at depth L.
  - A div loads `div_cnt`=LAT_DIV-1 (counts to 0).
- Non-div ops may issue while a div is in progress, subject to `wb`.
- At the result cycle, `fpu_out`, `fpu_errors` and the tag are registered. `rsp_valid`=1 for exactly one cycle.
- Responses appear in completion order, not issue order.

## Timing
- Issue in cycle t; the FPU result is valid in cycle t+L. `rsp_*` is valid in cycle t+L+1.
- Throughput: one issue per cycle maximum. A second div can issue no earlier than t+LAT_DIV.
- Two requesters asserting in the same cycle: one grant; the loser waits at least one cycle.
- When no request is eligible: `fpu_start`=0, and `fpu_op`/`fpu_opa`/`fpu_opb` hold their last values.
- Reset (`rst_n`=0 at a rising edge) has these effects:
  - `wb` and the tag pipeline are cleared; `div_cnt`=0; `rr_ptr`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_error`=0.
  - While `rst_n`=0, `reqN_ready`=0 and `fpu_start`=0.
- Reset mid-operation discards every in-flight operation, and no response is ever emitted for them.

## Structure
- Shared package `fpu_pkg` holds:
  - op encodings `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`
  - the default latency constants
  - the width constant (`BIT_SIZE`)
- One sub-module is natural: `fpu_wb_tracker`, which owns the reservation vector, tag pipeline, div counter and response registers. The top level holds the arbiter and the operand mux.

## Test plan
- Single add from req0, opa=0x3F800000, opb=0x40000000, model returns 0x40400000 at t+2 -> `rsp_valid` at t+3, `rsp_id`=0, `rsp_data`=0x40400000, `rsp_error`=0.
- Both requesters assert an add in the first cycle after reset -> req0 granted at t, req1 at t+1. Responses at t+3 (id 0) and t+4 (id 1).
- req0 mul at t, req1 add at t+1 (its result would collide at t+3) -> `req1_ready`=0 at t+1. Add issues at t+2, responses at t+4 (mul) and t+5 (add).
- Two back-to-back divs from req0 -> second issued at t+8. An add from req1 at t+2 is granted immediately.
- Model drives `fpu_errors`=1 in the result cycle of a sub -> `rsp_error`=1 with that response only.
- Mul issued at t, `rst_n`=0 for cycle t+1 -> no `rsp_valid` through t+10. All outputs read 0 after the reset edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Encodings and default sizing shared by the FPU issue controller and its
// writeback tracker.
package fpu_pkg;

  localparam int BIT_SIZE    = 31;
  localparam int DEF_LAT_ADD = 2;
  localparam int DEF_LAT_MUL = 3;
  localparam int DEF_LAT_DIV = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  function automatic logic is_div(input logic [1:0] op);
    return op == OP_DIV;
  endfunction

endpackage

// File: rtl/fpu_wb_tracker.sv
// Tracks in-flight FPU operations: result-bus reservations, requester tags,
// the divider busy counter, and the registered response.
module fpu_wb_tracker
  import fpu_pkg::*;
#(
  parameter int WIDTH   = BIT_SIZE + 1,
  parameter int LAT_ADD = DEF_LAT_ADD,
  parameter int LAT_MUL = DEF_LAT_MUL,
  parameter int LAT_DIV = DEF_LAT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  input  logic             issue_id_i,
  input  logic [1:0]       issue_op_i,
  input  logic [WIDTH-1:0] fpu_out_i,
  input  logic             fpu_errors_i,
  output logic [LAT_DIV:0] wb_o,
  output logic             div_busy_o,
  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_error_o
);

  localparam int CW = $clog2(LAT_DIV + 1);

  // Bit k set: a result lands on the FPU bus k cycles from now (bit 0 = this cycle).
  logic [LAT_DIV:0] wb_q, wb_d;
  logic [LAT_DIV:0] tag_q, tag_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;

  assign div_busy_o = (div_cnt_q != '0);

  always_comb begin
    wb_d      = {1'b0, wb_q[LAT_DIV:1]};
    tag_d     = {1'b0, tag_q[LAT_DIV:1]};
    div_cnt_d = div_busy_o ? div_cnt_q - CW'(1) : div_cnt_q;

    // A new issue lands one slot below its latency because the vector has
    // already advanced by the time it is next looked at.
    if (issue_i) begin
      case (issue_op_i)
        OP_MUL: begin
          wb_d[LAT_MUL-1]  = 1'b1;
          tag_d[LAT_MUL-1] = issue_id_i;
        end
        OP_DIV: begin
          wb_d[LAT_DIV-1]  = 1'b1;
          tag_d[LAT_DIV-1] = issue_id_i;
          div_cnt_d        = CW'(LAT_DIV - 1);
        end
        default: begin
          wb_d[LAT_ADD-1]  = 1'b1;
          tag_d[LAT_ADD-1] = issue_id_i;
        end
      endcase
    end

    rsp_valid_d = wb_q[0];
    rsp_id_d    = wb_q[0] ? tag_q[0]     : rsp_id_q;
    rsp_data_d  = wb_q[0] ? fpu_out_i    : rsp_data_q;
    rsp_error_d = wb_q[0] ? fpu_errors_i : rsp_error_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q        <= '0;
      tag_q       <= '0;
      div_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      tag_q       <= tag_d;
      div_cnt_q   <= div_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign wb_o        = wb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_error_o = rsp_error_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Round-robin issue arbiter sharing one FPU between two requesters, with a
// collision-free writeback schedule and tagged responses.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int WIDTH   = BIT_SIZE + 1,
  parameter int LAT_ADD = DEF_LAT_ADD,
  parameter int LAT_MUL = DEF_LAT_MUL,
  parameter int LAT_DIV = DEF_LAT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req0_opa,
  input  logic [WIDTH-1:0] req0_opb,
  input  logic [WIDTH-1:0] req1_opa,
  input  logic [WIDTH-1:0] req1_opb,
  output logic             fpu_start,
  output logic [1:0]       fpu_op,
  output logic [WIDTH-1:0] fpu_opa,
  output logic [WIDTH-1:0] fpu_opb,
  input  logic [WIDTH-1:0] fpu_out,
  input  logic             fpu_errors,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error
);

  logic [LAT_DIV:0] wb;
  logic             div_busy;
  logic             elig0, elig1, grant0, grant1;
  logic             rr_q, rr_d;
  logic [1:0]       last_op_q;
  logic [WIDTH-1:0] last_opa_q, last_opb_q;

  function automatic logic slot_free(input logic [1:0] op, input logic [LAT_DIV:0] wbv);
    case (op)
      OP_MUL:  return !wbv[LAT_MUL];
      OP_DIV:  return !wbv[LAT_DIV];
      default: return !wbv[LAT_ADD];
    endcase
  endfunction

  assign elig0 = rst_n & req0_valid & slot_free(req0_op, wb) & ~(is_div(req0_op) & div_busy);
  assign elig1 = rst_n & req1_valid & slot_free(req1_op, wb) & ~(is_div(req1_op) & div_busy);

  always_comb begin
    grant0    = elig0 & (~elig1 | ~rr_q);
    grant1    = elig1 & (~elig0 | rr_q);
    rr_d      = rr_q;
    fpu_start = grant0 | grant1;
    fpu_op    = last_op_q;
    fpu_opa   = last_opa_q;
    fpu_opb   = last_opb_q;
    if (grant0) begin
      rr_d    = 1'b1;
      fpu_op  = req0_op;
      fpu_opa = req0_opa;
      fpu_opb = req0_opb;
    end else if (grant1) begin
      rr_d    = 1'b0;
      fpu_op  = req1_op;
      fpu_opa = req1_opa;
      fpu_opb = req1_opb;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The FPU-facing operands hold their last issued values while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      last_op_q  <= '0;
      last_opa_q <= '0;
      last_opb_q <= '0;
    end else begin
      rr_q       <= rr_d;
      last_op_q  <= fpu_op;
      last_opa_q <= fpu_opa;
      last_opb_q <= fpu_opb;
    end
  end

  fpu_wb_tracker #(
    .WIDTH   (WIDTH),
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV)
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_i      (fpu_start),
    .issue_id_i   (grant1),
    .issue_op_i   (fpu_op),
    .fpu_out_i    (fpu_out),
    .fpu_errors_i (fpu_errors),
    .wb_o         (wb),
    .div_busy_o   (div_busy),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .rsp_error_o  (rsp_error)
  );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed vector table plus randomized traffic,
// both checked against a cycle-indexed schedule model and a stand-in FPU.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int W  = 32;
  localparam int LA = 2;
  localparam int LM = 3;
  localparam int LD = 8;
  localparam int N  = 4096;

  localparam logic [31:0] A0 = 32'h3F80_0000;
  localparam logic [31:0] B0 = 32'h4000_0000;
  localparam logic [31:0] A1 = 32'h0000_0064;
  localparam logic [31:0] B1 = 32'h0000_0007;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [W-1:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic fpu_start;
  logic [1:0] fpu_op;
  logic [W-1:0] fpu_opa, fpu_opb, fpu_out;
  logic fpu_errors;
  logic rsp_valid, rsp_id, rsp_error;
  logic [W-1:0] rsp_data;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.WIDTH(W), .LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req1_opa(req1_opa), .req1_opb(req1_opb),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_out(fpu_out), .fpu_errors(fpu_errors),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error)
  );

  int checks = 0;
  int passes = 0;
  int cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cur, act, exp);
  endtask

  function automatic int lat(input logic [1:0] op);
    case (op)
      OP_MUL:  return LM;
      OP_DIV:  return LD;
      default: return LA;
    endcase
  endfunction

  // Stand-in arithmetic for the FPU; only needs to be deterministic and distinct.
  function automatic logic [31:0] fake(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  // Reference model, indexed by absolute cycle number.
  logic        occ [N];
  logic        ev  [N];
  logic        eid [N];
  logic [31:0] ed  [N];
  logic        ee  [N];
  // Stand-in FPU result schedule (not affected by controller reset).
  logic        fv  [N];
  logic [31:0] fd  [N];
  logic        fe  [N];
  int          div_free_at = 0;
  logic        rr = 1'b0;
  logic [1:0]  last_op = 2'b00;
  logic [31:0] last_a = '0, last_b = '0;
  logic        prev_rst = 1'b1;
  logic        m_g0, m_g1;

  task automatic run_cycle(input logic rs,
                           input logic v0, input logic [1:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic v1, input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                           input logic er);
    logic e0, e1, id;
    logic [1:0] xo;
    logic [31:0] xa, xb;
    int idx;
    rst_n = rs;
    req0_valid = v0; req0_op = o0; req0_opa = a0; req0_opb = b0;
    req1_valid = v1; req1_op = o1; req1_opa = a1; req1_opb = b1;
    fpu_out    = fv[cur] ? fd[cur] : 32'hDEAD_BEEF;
    fpu_errors = fv[cur] ? fe[cur] : 1'b1;
    #1;
    e0 = rs && v0 && !occ[cur + lat(o0)] && !(o0 == OP_DIV && cur < div_free_at);
    e1 = rs && v1 && !occ[cur + lat(o1)] && !(o1 == OP_DIV && cur < div_free_at);
    if (e0 && e1) begin m_g0 = !rr; m_g1 = rr; end
    else begin m_g0 = e0; m_g1 = e1; end
    xo = m_g0 ? o0 : m_g1 ? o1 : last_op;
    xa = m_g0 ? a0 : m_g1 ? a1 : last_a;
    xb = m_g0 ? b0 : m_g1 ? b1 : last_b;
    chk("req0_ready", req0_ready, m_g0);
    chk("req1_ready", req1_ready, m_g1);
    chk("fpu_start", fpu_start, m_g0 | m_g1);
    chk("fpu_op", fpu_op, xo);
    chk("fpu_opa", fpu_opa, xa);
    chk("fpu_opb", fpu_opb, xb);
    chk("rsp_valid", rsp_valid, ev[cur]);
    if (ev[cur]) begin
      chk("rsp_id", rsp_id, eid[cur]);
      chk("rsp_data", rsp_data, ed[cur]);
      chk("rsp_error", rsp_error, ee[cur]);
    end
    if (prev_rst) begin
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_error", rsp_error, 0);
    end
    if (fpu_start === 1'b1) begin
      idx = cur + lat(fpu_op);
      fv[idx] = 1'b1;
      fd[idx] = fake(fpu_op, fpu_opa, fpu_opb);
      fe[idx] = er;
    end
    if (!rs) begin
      for (int k = cur + 1; k < N; k++) begin occ[k] = 1'b0; ev[k] = 1'b0; end
      div_free_at = 0; rr = 1'b0; last_op = '0; last_a = '0; last_b = '0;
    end else if (m_g0 || m_g1) begin
      id = m_g1;
      occ[cur + lat(xo)] = 1'b1;
      ev[cur + lat(xo) + 1]  = 1'b1;
      eid[cur + lat(xo) + 1] = id;
      ed[cur + lat(xo) + 1]  = fake(xo, xa, xb);
      ee[cur + lat(xo) + 1]  = er;
      if (xo == OP_DIV) div_free_at = cur + LD;
      rr = !id;
      last_op = xo; last_a = xa; last_b = xb;
    end
    prev_rst = !rs;
  endtask

  typedef struct {
    logic rs, v0; logic [1:0] o0; logic v1; logic [1:0] o1; logic er;
    logic r0, r1, rv, rid, rerr; logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic rs, input logic v0, input logic [1:0] o0, input logic v1, input logic [1:0] o1,
                     input logic er, input logic r0, input logic r1,
                     input logic rv, input logic rid, input logic rerr, input logic [31:0] rd);
    vec_t v;
    v.rs = rs; v.v0 = v0; v.o0 = o0; v.v1 = v1; v.o1 = o1; v.er = er;
    v.r0 = r0; v.r1 = r1; v.rv = rv; v.rid = rid; v.rerr = rerr; v.rd = rd;
    tbl.push_back(v);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) row(1, 0, OP_ADD, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rspr(input logic id, input logic err, input logic [31:0] d);
    row(1, 0, OP_ADD, 0, OP_ADD, 0, 0, 0, 1, id, err, d);
  endtask

  logic p0 = 1'b0, p1 = 1'b0;
  logic [1:0] q0o = 2'b00, q1o = 2'b00;
  logic [31:0] q0a = '0, q0b = '0, q1a = '0, q1b = '0;

  initial begin
    for (int k = 0; k < N; k++) begin
      occ[k] = 0; ev[k] = 0; eid[k] = 0; ed[k] = 0; ee[k] = 0; fv[k] = 0; fd[k] = 0; fe[k] = 0;
    end
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_opa = 0; req0_opb = 0; req1_opa = 0; req1_opb = 0;
    fpu_out = 0; fpu_errors = 0;
    @(negedge clk);
    @(negedge clk);

    // Single add from req0
    row(1, 1, OP_ADD, 0, OP_ADD, 0, 1, 0, 0, 0, 0, 0);
    quiet(2);
    rspr(0, 0, 32'h4040_0000);
    quiet(1);
    // Reset, then both requesters add in the first cycle
    row(0, 0, OP_ADD, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, OP_ADD, 1, OP_ADD, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, OP_ADD, 1, OP_ADD, 0, 0, 1, 0, 0, 0, 0);
    quiet(1);
    rspr(0, 0, 32'h4040_0000);
    rspr(1, 0, 32'h0000_006B);
    quiet(1);
    // Mul then colliding add
    row(1, 1, OP_MUL, 0, OP_ADD, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, OP_MUL, 1, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, OP_MUL, 1, OP_ADD, 0, 0, 1, 0, 0, 0, 0);
    quiet(1);
    rspr(0, 0, 32'h0000_0000);
    rspr(1, 0, 32'h0000_006B);
    quiet(1);
    // Back-to-back divs with an add slipped in
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 1, 0, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 1, OP_ADD, 0, 0, 1, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 0, 0, 1, 1, 0, 32'h0000_006B);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, OP_DIV, 0, OP_ADD, 0, 1, 0, 0, 0, 0, 0);
    rspr(0, 0, 32'h0000_0000);
    quiet(7);
    rspr(0, 0, 32'h0000_0000);
    quiet(1);
    // Error flag on a sub only
    row(1, 0, OP_ADD, 1, OP_SUB, 1, 0, 1, 0, 0, 0, 0);
    row(1, 1, OP_ADD, 0, OP_SUB, 0, 1, 0, 0, 0, 0, 0);
    quiet(1);
    rspr(1, 1, 32'h0000_005D);
    rspr(0, 0, 32'h4040_0000);
    quiet(1);
    // Mul killed by reset mid-flight
    row(1, 1, OP_MUL, 0, OP_ADD, 0, 1, 0, 0, 0, 0, 0);
    row(0, 0, OP_ADD, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    quiet(10);

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i].rs, tbl[i].v0, tbl[i].o0, A0, B0, tbl[i].v1, tbl[i].o1, A1, B1, tbl[i].er);
      chk("tbl_ready0", req0_ready, tbl[i].r0);
      chk("tbl_ready1", req1_ready, tbl[i].r1);
      chk("tbl_rsp_valid", rsp_valid, tbl[i].rv);
      if (tbl[i].rv) begin
        chk("tbl_rsp_id", rsp_id, tbl[i].rid);
        chk("tbl_rsp_error", rsp_error, tbl[i].rerr);
        chk("tbl_rsp_data", rsp_data, tbl[i].rd);
      end
      @(negedge clk);
      cur++;
    end

    for (int n = 0; n < 1500; n++) begin
      logic rs, er;
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1'b1; q0o = 2'($urandom_range(0, 3)); q0a = $urandom; q0b = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1'b1; q1o = 2'($urandom_range(0, 3)); q1a = $urandom; q1b = $urandom;
      end
      rs = ($urandom_range(0, 199) != 0);
      er = ($urandom_range(0, 3) == 0);
      run_cycle(rs, p0, q0o, q0a, q0b, p1, q1o, q1a, q1b, er);
      if (m_g0) p0 = 1'b0;
      if (m_g1) p1 = 1'b0;
      @(negedge clk);
      cur++;
    end

    for (int n = 0; n < LD + 4; n++) begin
      run_cycle(1, 0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0);
      @(negedge clk);
      cur++;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
